load_store_unit: RTL
====================

# load_store_unit

Data-memory access stage sitting directly downstream of the ALU: takes the ALU result as the effective address for lw/lh/lhu/lb/lbu/sw/sh/sb. Drives a word-wide request/acknowledge memory bus with arbitrary wait states. Stalls the single-cycle datapath (holds PC and register writes) until the access completes, and returns aligned, sign- or zero-extended load data to the write-back mux.

## Interface
- `TIMEOUT_CYCLES`, default 255: ACCESS cycles without `BusAck` before the access is abandoned; 0 disables the watchdog.
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `MemRead`  in  1  load request (from control unit)
- `MemWrite`  in  1  store request (from control unit)
- `MemSize`  in  2  00 byte, 01 half, 10 word, 11 reserved
- `MemUnsigned`  in  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
- `Address`  in  32  effective address (`ALUResult`)
- `WriteData`  in  32  store data (rt value)
- `ReadData`  out  32  extended load result
- `Stall`  out  1  hold PC/register file this cycle
- `AddrError`  out  1  misaligned or reserved-size request
- `BusError`  out  1  one-cycle pulse on watchdog timeout
- `BusReq`, `BusWe`  out  1 each  request valid; 1 = write
- `BusAddr`  out  32  word address, bits [1:0] always 00
- `BusByteEn`  out  4  byte lane enables, little-endian (lane i = bits 8i+7:8i)
- `BusWData`  out  32  lane-replicated store data
- `BusRData`  in  32  read data, valid with `BusAck`
- `BusAck`  in  1  access complete

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: request = `MemRead | MemWrite`. If the request is legal, register bus fields and go to ACCESS. Otherwise stay in IDLE.
- ACCESS: `BusReq`=1 and all bus fields held stable.
  - On `BusAck`: capture the load result and go to DONE.
  - On watchdog expiry: pulse `BusError`, set `ReadData`=0, go to DONE.
- DONE: `Stall`=0 so the PC advances at this edge; return to IDLE unconditionally.
- Write priority: `MemRead` and `MemWrite` both high is executed as a store, and `ReadData` is unchanged.
- Legality:
  - half requires `Address[0]`=0.
  - word requires `Address[1:0]`=00.
  - `MemSize`=11 is always illegal.
- An illegal request in IDLE produces:
  - `AddrError`=1 combinationally, `Stall`=0.
  - No bus request; FSM stays in IDLE.
- Byte enables:
  - byte: 0001 << `Address[1:0]`.
  - half: 0011 if `Address[1]`=0, else 1100.
  - word: 1111.
- Store data:
  - byte: {4{`WriteData[7:0]`}}.
  - half: {2{`WriteData[15:0]`}}.
  - word: passed through unchanged.
- Load extract: select the lane addressed by `Address[1:0]`, then extend to 32 bits per `MemUnsigned`.
- `ReadData` is registered. It updates only on a completed load or a timed-out load, and holds otherwise.
- `BusAck` outside ACCESS is ignored.
- Reset mid-operation: FSM goes to IDLE immediately and `BusReq` drops asynchronously. The aborted access is not retried by this block.

## Timing
- Reset values: `BusReq`, `BusWe`, `BusAddr`, `BusByteEn`, `BusWData`, `ReadData`, `BusError` are all 0. `Stall` and `AddrError` are forced to 0 while `reset` is low.
- `Stall` = (IDLE & legal request) | ACCESS, combinational.
- Minimum access is 3 cycles: IDLE, ACCESS with `BusAck` in its first cycle, then DONE.
- Each wait state adds one ACCESS cycle.
- `ReadData` is valid in the DONE cycle and afterwards.
- Watchdog counter:
  - Clears on entering ACCESS and increments each ACCESS cycle without `BusAck`.
  - Expires when the count equals `TIMEOUT_CYCLES`.
  - `BusAck` and expiry in the same cycle: the ack wins and there is no `BusError`.
- `BusReq` is 1 only in ACCESS. It falls at the edge entering DONE, so back-to-back accesses have at least one idle bus cycle.

## Structure
- Shared package/header holds:
  - `MemSize` encodings `MEM_BYTE`, `MEM_HALF`, `MEM_WORD`.
  - FSM state encodings.
- Sub-module `lsu_lane_align`, purely combinational:
  - Computes byte enables, store replication, load extraction/extension and the legality check.
  - Instantiated once.
- Top-level holds the FSM, watchdog counter and output registers.

## Test plan
- Word load: `Address`=0x100, `BusAck` after 2 wait states, `BusRData`=0xDEADBEEF.
  - `Stall` high 4 cycles; `BusAddr`=0x100; `BusByteEn`=1111; `ReadData`=0xDEADBEEF in DONE.
- Byte loads at `Address`=0x203 with `BusRData`=0x80123456.
  - Signed: `BusByteEn`=1000, `ReadData`=0xFFFFFF80.
  - Unsigned: `ReadData`=0x00000080.
- Half store at `Address`=0x302, `WriteData`=0x0000ABCD, immediate ack.
  - `BusWe`=1, `BusByteEn`=1100, `BusWData`=0xABCDABCD, `BusAddr`=0x300.
  - `ReadData` unchanged.
- Misaligned and reserved requests: word load at 0x101; half store at 0x003; `MemSize`=11.
  - Each gives `AddrError`=1, `Stall`=0, `BusReq` never asserted.
- Timeout: `TIMEOUT_CYCLES`=4, no ack.
  - `BusError` pulses once after 4 ACCESS cycles; `ReadData`=0; FSM returns to IDLE.
  - Repeat with ack in the expiry cycle: no `BusError`.
- Reset asserted in the 2nd ACCESS cycle.
  - `BusReq` falls without a clock edge; all outputs at reset values.
  - A new load after release completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared encodings and payload types for the load/store unit.
package load_store_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [3:0]      byte_en;
        logic [XLEN-1:0] wdata;
    } bus_req_t;

    // Load context remembered across the access so the datapath inputs may move.
    typedef struct packed {
        logic       is_load;
        logic [1:0] size;
        logic       zext;
        logic [1:0] addr_lo;
    } ld_ctx_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: legality, byte enables, store replication, load extract/extend.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  ld_size,
    input  logic        ld_zext,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic        legal_c,
    output logic [3:0]  byte_en_c,
    output logic [31:0] wdata_c,
    output logic [31:0] rdata_c
);

    logic [31:0] shifted;

    // Request side: lane enables and replicated store data.
    always_comb begin
        legal_c   = 1'b0;
        byte_en_c = 4'b0000;
        wdata_c   = '0;
        case (req_size)
            MEM_BYTE: begin
                legal_c   = 1'b1;
                byte_en_c = 4'b0001 << req_addr_lo;
                wdata_c   = {4{req_wdata[7:0]}};
            end
            MEM_HALF: begin
                legal_c   = ~req_addr_lo[0];
                byte_en_c = req_addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_c   = {2{req_wdata[15:0]}};
            end
            MEM_WORD: begin
                legal_c   = (req_addr_lo == 2'b00);
                byte_en_c = 4'b1111;
                wdata_c   = req_wdata;
            end
            default: ;
        endcase
    end

    // Response side: shift addressed lane down to bit 0, then extend.
    always_comb begin
        shifted = ld_rdata >> {ld_addr_lo, 3'b000};
        case (ld_size)
            MEM_BYTE: rdata_c = {{24{~ld_zext & shifted[7]}}, shifted[7:0]};
            MEM_HALF: rdata_c = {{16{~ld_zext & shifted[15]}}, shifted[15:0]};
            default:  rdata_c = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: drives a req/ack bus, stalls the datapath, returns extended load data.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        AddrError,
    output logic        BusError,
    output logic        BusReq,
    output logic        BusWe,
    output logic [31:0] BusAddr,
    output logic [3:0]  BusByteEn,
    output logic [31:0] BusWData,
    input  logic [31:0] BusRData,
    input  logic        BusAck
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    lsu_state_e       state_q, state_d;
    bus_req_t         bus_q, bus_d;
    ld_ctx_t          ld_q, ld_d;
    logic             bus_req_q, bus_req_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             bus_error_q, bus_error_d;

    logic             req_c, legal_c, idle_c, access_c, start_c, wd_hit_c;
    logic [WD_W-1:0]  wd_inc_c;
    logic [3:0]       byte_en_c;
    logic [31:0]      wdata_c, ld_rdata_c;

    lsu_lane_align u_align (
        .req_size    (MemSize),
        .req_addr_lo (Address[1:0]),
        .req_wdata   (WriteData),
        .ld_size     (ld_q.size),
        .ld_zext     (ld_q.zext),
        .ld_addr_lo  (ld_q.addr_lo),
        .ld_rdata    (BusRData),
        .legal_c     (legal_c),
        .byte_en_c   (byte_en_c),
        .wdata_c     (wdata_c),
        .rdata_c     (ld_rdata_c)
    );

    assign req_c    = MemRead | MemWrite;
    assign idle_c   = (state_q == ST_IDLE);
    assign access_c = (state_q == ST_ACCESS);
    assign start_c  = idle_c & req_c & legal_c;
    assign wd_inc_c = wd_cnt_q + WD_W'(1);
    // The cycle that would bring the count to the limit is the expiry cycle.
    assign wd_hit_c = (TIMEOUT_CYCLES != 0) && (wd_inc_c == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bus_q       <= '0;
            ld_q        <= '0;
            bus_req_q   <= 1'b0;
            wd_cnt_q    <= '0;
            read_data_q <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            ld_q        <= ld_d;
            bus_req_q   <= bus_req_d;
            wd_cnt_q    <= wd_cnt_d;
            read_data_q <= read_data_d;
            bus_error_q <= bus_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_d       = bus_q;
        ld_d        = ld_q;
        bus_req_d   = bus_req_q;
        wd_cnt_d    = wd_cnt_q;
        read_data_d = read_data_q;
        bus_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_c) begin
                    state_d         = ST_ACCESS;
                    bus_req_d       = 1'b1;
                    wd_cnt_d        = '0;
                    bus_d.we        = MemWrite;
                    bus_d.addr      = {Address[31:2], 2'b00};
                    bus_d.byte_en   = byte_en_c;
                    bus_d.wdata     = wdata_c;
                    ld_d.is_load    = ~MemWrite;
                    ld_d.size       = MemSize;
                    ld_d.zext       = MemUnsigned;
                    ld_d.addr_lo    = Address[1:0];
                end
            end
            ST_ACCESS: begin
                if (BusAck) begin
                    state_d   = ST_DONE;
                    bus_req_d = 1'b0;
                    if (ld_q.is_load) begin
                        read_data_d = ld_rdata_c;
                    end
                end else if (wd_hit_c) begin
                    state_d     = ST_DONE;
                    bus_req_d   = 1'b0;
                    bus_error_d = 1'b1;
                    if (ld_q.is_load) begin
                        read_data_d = '0;
                    end
                end else begin
                    wd_cnt_d = wd_inc_c;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign Stall     = reset & (start_c | access_c);
    assign AddrError = reset & idle_c & req_c & ~legal_c;
    assign BusReq    = bus_req_q;
    assign BusWe     = bus_q.we;
    assign BusAddr   = bus_q.addr;
    assign BusByteEn = bus_q.byte_en;
    assign BusWData  = bus_q.wdata;
    assign ReadData  = read_data_q;
    assign BusError  = bus_error_q;

endmodule
